// File: rtl/mul_pkg.sv
// Shared types and saturation bounds for the multiply-accumulate stage.
package mul_pkg;

   typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} mac_state_t;

   // Largest and smallest values of a w-bit two's-complement number
   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed add that clamps to the W-bit range on overflow.
module sat_add
   import mul_pkg::*;
#(
   parameter int W = 20
) (
   input  logic signed [W-1:0] acc,
   input  logic signed [W-1:0] addend,
   output logic signed [W-1:0] sum,
   output logic                ovf
);

   localparam logic signed [W-1:0] SMAX = W'(sat_max(W));
   localparam logic signed [W-1:0] SMIN = W'(sat_min(W));

   logic signed [W:0] ext;

   // One guard bit: the top two bits disagree exactly on signed overflow
   assign ext = {acc[W-1], acc} + {addend[W-1], addend};
   assign ovf = ext[W] ^ ext[W-1];

   always_comb begin
      sum = ext[W-1:0];
      if (ovf) sum = ext[W] ? SMIN : SMAX;
   end

endmodule

// File: rtl/mac_acc.sv
// Streaming signed MAC: registered product, saturating accumulator, per-frame
// result presented on a valid/ready handshake and cleared on acceptance.
module mac_acc
   import mul_pkg::*;
#(
   parameter int N    = 8,
   parameter int ACCW = 20,
   parameter int CNTW = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [N-1:0]    a,
   input  logic signed [N-1:0]    b,
   input  logic                   last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [ACCW-1:0] acc,
   output logic [CNTW-1:0]        count,
   output logic                   sat
);

   if (ACCW < 2 * N) begin : g_width_chk
      $error("mac_acc: ACCW must be at least 2*N");
   end

   mac_state_t state, state_nxt;

   logic signed [2*N-1:0]  p;
   logic                   pvalid;
   logic                   plast;
   logic                   accept;
   logic signed [ACCW-1:0] addend;
   logic signed [ACCW-1:0] sum;
   logic                   ovf;

   // Ready comes from registered state only, never from out_ready
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p      <= '0;
         pvalid <= 1'b0;
         plast  <= 1'b0;
      end else begin
         pvalid <= accept;
         plast  <= accept && last;
         if (accept) p <= (2*N)'(a) * (2*N)'(b);
      end
   end

   assign addend = ACCW'(p);

   sat_add #(.W(ACCW)) u_sat_add (
      .acc    (acc),
      .addend (addend),
      .sum    (sum),
      .ovf    (ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
         sat   <= 1'b0;
      end else if (state == HOLD && out_ready) begin
         acc   <= '0;
         count <= '0;
         sat   <= 1'b0;
      end else if (pvalid) begin
         acc <= sum;
         if (count != '1) count <= count + CNTW'(1);
         if (ovf) sat <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (accept && last) state_nxt = FLUSH;
         FLUSH: if (plast)          state_nxt = HOLD;
         HOLD:  if (out_ready)      state_nxt = ACCUM;
         default:                   state_nxt = ACCUM;
      endcase
   end

endmodule
